// File: rtl/iobuf_bus_turnaround_ctrl.sv
// Half-duplex pad bus sequencer: round-robin between two requesters,
// with automatic released turnaround cycles whenever the bus direction flips.
module iobuf_bus_turnaround_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TURN    = 2,
    parameter int HOLD    = 1,
    parameter int RD_WAIT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             WR0,
    input  logic [WIDTH-1:0] WDATA0,
    output logic             ACK0,
    input  logic             REQ1,
    input  logic             WR1,
    input  logic [WIDTH-1:0] WDATA1,
    output logic             ACK1,
    output logic [WIDTH-1:0] RDATA,
    output logic [WIDTH-1:0] IO_I,
    output logic             IO_T,
    input  logic [WIDTH-1:0] IO_O,
    output logic             BUSY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_RWAIT = 2'd3;

    localparam int MAX_A = (TURN > HOLD) ? TURN : HOLD;
    localparam int MAXC  = (MAX_A > RD_WAIT) ? MAX_A : RD_WAIT;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Counters load length-1 and the phase ends when they reach zero.
    localparam logic [CW-1:0] TURN_LD = CW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] RDW_LD  = CW'(RD_WAIT - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             ptr;
    logic             last_dir;
    logic             cur_id;
    logic             cur_wr;
    logic [WIDTH-1:0] cur_wdata;

    logic             elig0;
    logic             elig1;
    logic             gnt;
    logic             gnt_id;
    logic             gnt_wr;
    logic [WIDTH-1:0] gnt_wdata;

    // A requester is masked in its own ACK cycle so a held REQ is not re-granted.
    assign elig0     = REQ0 & ~ACK0;
    assign elig1     = REQ1 & ~ACK1;
    assign gnt       = elig0 | elig1;
    assign gnt_id    = (elig0 & elig1) ? ptr : elig1;
    assign gnt_wr    = gnt_id ? WR1 : WR0;
    assign gnt_wdata = gnt_id ? WDATA1 : WDATA0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= 1'b0;
            last_dir  <= 1'b0;
            cur_id    <= 1'b0;
            cur_wr    <= 1'b0;
            cur_wdata <= '0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            RDATA     <= '0;
            IO_I      <= '0;
            IO_T      <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (gnt) begin
                        ptr       <= ~gnt_id;
                        cur_id    <= gnt_id;
                        cur_wr    <= gnt_wr;
                        cur_wdata <= gnt_wdata;
                        BUSY      <= 1'b1;
                        if (TURN > 0 && gnt_wr != last_dir) begin
                            state <= S_TURN;
                            cnt   <= TURN_LD;
                        end else if (gnt_wr) begin
                            state    <= S_DRIVE;
                            cnt      <= HOLD_LD;
                            IO_T     <= 1'b0;
                            IO_I     <= gnt_wdata;
                            last_dir <= 1'b1;
                        end else begin
                            state    <= S_RWAIT;
                            cnt      <= RDW_LD;
                            last_dir <= 1'b0;
                        end
                    end
                end
                S_TURN: begin
                    if (cnt == '0) begin
                        last_dir <= cur_wr;
                        if (cur_wr) begin
                            state <= S_DRIVE;
                            cnt   <= HOLD_LD;
                            IO_T  <= 1'b0;
                            IO_I  <= cur_wdata;
                        end else begin
                            state <= S_RWAIT;
                            cnt   <= RDW_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        IO_T  <= 1'b1;
                        BUSY  <= 1'b0;
                        if (cur_id) ACK1 <= 1'b1;
                        else        ACK0 <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RWAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        RDATA <= IO_O;
                        BUSY  <= 1'b0;
                        if (cur_id) ACK1 <= 1'b1;
                        else        ACK0 <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
